phase_unwrap: RTL
=================

// Module: phase_unwrap
// PURPOSE
//  Inverse companion of the saturating phase detector. It takes a modular (wrapping) w-bit
//  phase stream and rebuilds a continuous, extended-range (w+e)-bit phase by accumulating
//  shortest-path modular differences.
//  Sits after CORDIC/angle extraction. Feeds loop filters and logging that need a
//  multi-turn phase instead of a wrapped one.
// PARAMETERS
//  w   18  input phase width; full turn = 2^w, signed two's complement
//  e   6   extra output bits; output range +/-2^(w+e-1), i.e. +/-32 turns at defaults
//  slip_thr 16  log2 threshold for the slip flag: |delta| >= 2^slip_thr is flagged
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  reset      in   1      synchronous, active-high
//  ang_in     in   w      signed wrapped phase, valid when strobe_in=1
//  strobe_in  in   1      input sample valid
//  sat_clear  in   1      clears sticky sat flag (synchronous, single cycle)
//  ang_out    out  w+e    signed unwrapped phase
//  strobe_out out  1      output valid, strobe_in delayed 1 cycle
//  slip       out  1      one-cycle pulse with strobe_out: |delta| >= 2^slip_thr (aliasing risk)
//  sat        out  1      sticky: accumulator clamped at least once since reset/sat_clear
// BEHAVIOUR
//  Reset: ang_out=0, strobe_out=0, slip=0, sat=0, internal prev=0, primed=0.
//  States: IDLE (primed=0) -> RUN (primed=1). Leave IDLE on first strobe_in. Only reset returns to IDLE.
//  IDLE + strobe_in: acc <= sext(ang_in); prev <= ang_in; slip=0; no saturation check.
//  RUN + strobe_in: delta = (ang_in - prev) mod 2^w, read as signed w-bit.
//    Exact half-turn -2^(w-1) is kept as negative, with no tie-break logic.
//    sum = acc + sext(delta), computed in w+e+1 bits.
//    If sum > 2^(w+e-1)-1: acc <= max and sat <= 1. If sum < -2^(w+e-1): acc <= min and sat <= 1.
//    Otherwise acc <= sum.
//    prev <= ang_in always, so the phase keeps tracking while clamped.
//    Later deltas move away from the clamp normally.
//  strobe_in=0: acc, prev, ang_out held. strobe_out=0, slip=0.
//  Latency: exactly 1 clk, strobe_in to strobe_out. ang_out updates in the same cycle as
//    strobe_out and holds between strobes.
//  slip = strobe_out & primed_prev & (|delta| >= 2^slip_thr). |-2^(w-1)| is treated as 2^(w-1).
//  sat_clear and a new clamp in the same cycle: the clamp wins, so sat stays 1.
//  Reset mid-stream: everything returns to reset values in the next cycle. The next strobe re-primes.
//  Back-to-back strobes every cycle are supported with no bubbles.
// TESTING
//  1 Ramp: strobe every clk, ang_in += 7000 from 0 for 150 samples.
//    Expect ang_out = 7000*k after sample k (1,043,000 at k=149), then 1,050,000 after the last.
//    No sat. No slip.
//  2 Reverse: continue with ang_in -= 5000 for 150 samples.
//    Expect ang_out to fall by 5000 per strobe to 300,000. Wrap crossings are invisible.
//  3 Saturation: ang_in += 100000 per strobe from 0.
//    Expect ang_out to clamp at 8,388,607 and sat=1 after the 84th delta.
//    Then step -100000: expect ang_out = 8,288,607 and sat still 1. Pulse sat_clear: expect sat=0.
//  4 Slip and half-turn: from ang_in=0, jump to -131072.
//    Expect ang_out = -131072 and slip=1 for one cycle.
//    Then a jump of +70000 gives slip=1. A jump of +1000 gives slip=0.
//  5 Gapped strobe: strobe every 3rd clk, ramp +4000.
//    Expect strobe_out exactly 1 clk after each strobe_in, and ang_out held in the gaps.
//  6 Reset mid-ramp at ang_out=500,000: expect all outputs 0 next clk.
//    The first strobe after reset with ang_in=12345 gives ang_out=12345 and slip=0.

Source files
------------

// File: rtl/phase_unwrap.sv
// Phase unwrapper: rebuilds a continuous multi-turn phase from a wrapped W-bit
// phase stream. It accumulates the shortest-path modular difference between
// successive samples into a saturating (W+E)-bit accumulator.
module phase_unwrap #(
    parameter int unsigned W        = 18,
    parameter int unsigned E        = 6,
    parameter int unsigned SLIP_THR = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     ang_in,
    input  logic             strobe_in,
    input  logic             sat_clear,
    output logic [W+E-1:0]   ang_out,
    output logic             strobe_out,
    output logic             slip,
    output logic             sat
);

    localparam int unsigned OW = W + E;
    localparam int unsigned SW = OW + 1;
    localparam logic [OW-1:0] ACC_MAX  = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] ACC_MIN  = {1'b1, {(OW-1){1'b0}}};
    localparam logic [W:0]    SLIP_LIM = (W+1)'(1) << SLIP_THR;

    // IDLE until the first sample primes prev/acc, then RUN until reset
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [OW-1:0]         acc_d;
    logic [W-1:0]          prev_q, prev_d;
    logic                  slip_d, sat_d;
    logic signed [W-1:0]   delta;
    logic signed [W:0]     delta_ext;
    logic [W:0]            delta_mag;
    logic signed [SW-1:0]  sum;

    // Next-state: modular delta, one-bit-wider sum, clamp and flag logic
    always_comb begin
        state_d   = state_q;
        acc_d     = ang_out;
        prev_d    = prev_q;
        slip_d    = 1'b0;
        sat_d     = sat_clear ? 1'b0 : sat;
        delta     = $signed(ang_in - prev_q);
        delta_ext = {delta[W-1], delta};
        delta_mag = unsigned'(delta_ext[W] ? -delta_ext : delta_ext);
        sum       = SW'($signed(ang_out)) + SW'(delta);

        if (strobe_in) begin
            prev_d = ang_in;
            case (state_q)
                IDLE: begin
                    acc_d   = OW'($signed(ang_in));
                    state_d = RUN;
                end
                RUN: begin
                    slip_d = (delta_mag >= SLIP_LIM);
                    // Top two sum bits disagree only when the result left the OW-bit range
                    if (sum[SW-1] != sum[SW-2]) begin
                        acc_d = sum[SW-1] ? ACC_MIN : ACC_MAX;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum[OW-1:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ang_out    <= '0;
            prev_q     <= '0;
            strobe_out <= 1'b0;
            slip       <= 1'b0;
            sat        <= 1'b0;
        end else begin
            state_q    <= state_d;
            ang_out    <= acc_d;
            prev_q     <= prev_d;
            strobe_out <= strobe_in;
            slip       <= slip_d;
            sat        <= sat_d;
        end
    end

endmodule
